// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - multi-word add/subtract sequencer driving an external 16-bit adder
module wide_add_seq #(
    parameter int WORDS = 2,
    localparam int W = 16 * WORDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sub,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         add_cin,
    output logic [15:0]  add_a,
    output logic [15:0]  add_b,
    input  logic         add_cout,
    input  logic [15:0]  add_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         sub_q;
    logic         carry_q;
    logic [3:0]   idx;
    logic [W-1:0] res_q;
    logic [W-1:0] res_nxt;
    logic         last;

    assign last     = (idx == 4'(WORDS - 1));
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[16*int'(idx) +: 16];
            add_b   = b_q[16*int'(idx) +: 16] ^ {16{sub_q}};
            add_cin = carry_q;
        end
    end

    // The final word bypasses res_q so flags see the complete result at the DONE edge.
    always_comb begin
        res_nxt                       = res_q;
        res_nxt[16*int'(idx) +: 16]   = add_r;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx       <= '0;
            res_q     <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        sub_q   <= in_sub;
                        carry_q <= in_sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    carry_q <= add_cout;
                    if (last) begin
                        out_valid <= 1'b1;
                        out_r     <= res_nxt;
                        out_cout  <= add_cout;
                        out_ovf   <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (add_r[15] != a_q[W-1]);
                        out_zero  <= (res_nxt == '0);
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq with a combinational adder model
module tb_wide_add_seq;

    localparam int WORDS = 2;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         add_cin;
    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cout;
    logic [15:0]  add_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int n_assert = 0;
    int n_fail   = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b),
        .add_cin(add_cin), .add_a(add_a), .add_b(add_b),
        .add_cout(add_cout), .add_r(add_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    assign {add_cout, add_r} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
    endtask

    // Accepts one request, checks every RUN word against plain arithmetic, ends in DONE.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] beff;
        logic [63:0]  m;
        logic [63:0]  s;
        beff = sub ? ~b : b;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_add_a", add_a, 0);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            m = (64'd1 << (16 * i)) - 64'd1;
            s = (64'(a) & m) + (64'(beff) & m) + 64'(sub);
            chk($sformatf("run%0d_add_a", i), add_a, a[16*i +: 16]);
            chk($sformatf("run%0d_add_b", i), add_b, beff[16*i +: 16]);
            chk($sformatf("run%0d_add_cin", i), add_cin, s[16*i]);
            chk($sformatf("run%0d_in_ready", i), in_ready, 0);
            chk($sformatf("run%0d_out_valid", i), out_valid, 0);
            @(negedge clk);
        end
        chk("latency_out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ovf;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W+1)'(sub);
        r    = full[W-1:0];
        if (sub) ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else     ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        chk("res_out_r", out_r, r);
        chk("res_out_cout", out_cout, full[W]);
        chk("res_out_ovf", out_ovf, ovf);
        chk("res_out_zero", out_zero, (r == 0));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_out_valid", out_valid, 0);
        chk("rel_in_ready", in_ready, 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        issue(a, b, sub);
        check_result(a, b, sub);
        release_out();
    endtask

    initial begin
        logic [W-1:0] held_r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values();
        reset_n = 1'b1;

        op(32'h0000FFFF, 32'h00000001, 1'b0);
        op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        op(32'h00010000, 32'h00000001, 1'b1);
        op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        op(32'h80000000, 32'h00000001, 1'b1);
        op(32'h12345678, 32'h12345678, 1'b1);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            op(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Backpressure: DONE must hold and ignore new requests.
        issue(32'h89ABCDEF, 32'h01234567, 1'b0);
        check_result(32'h89ABCDEF, 32'h01234567, 1'b0);
        held_r = out_r;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom_range(0, 1)) | (c == 0);
            in_a = $urandom; in_b = $urandom; in_sub = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_r", out_r, held_r);
        end
        in_valid = 1'b0;
        release_out();
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_ghost_valid", out_valid, 0);
            chk("bp_no_ghost_add_a", add_a, 0);
        end

        // Reset during the first RUN cycle.
        @(negedge clk);
        in_a = 32'hFFFF0001; in_b = 32'h00020003; in_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_run_add_a", add_a, 16'h0001);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_reset_values();
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_valid", out_valid, 0);
        end

        op(32'h00000000, 32'h00000000, 1'b0);
        op(32'h00000000, 32'h00000001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
